io_interconnect: RTL

IO_INTERCONNECT -- requirements
Module: io_interconnect

---
 rtl/io_interconnect_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/io_interconnect.sv | 133 +++++++++++++
 3 files changed

// File: rtl/io_interconnect_pkg.sv
// Shared IO request/response packet definitions for the core-to-bus interconnect.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_interconnect_pkg;

    // Core index width; a single-core build still carries a 1-bit field.
    localparam int CORE_ID_W    = (`NUM_CORES > 1) ? $clog2(`NUM_CORES) : 1;
    localparam int THREAD_IDX_W = 2;

    typedef logic [CORE_ID_W-1:0]    core_id_t;
    typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

    typedef struct packed {
        logic        store;
        logic [31:0] address;
        logic [31:0] value;
        thread_idx_t thread_idx;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t    core;
        thread_idx_t thread_idx;
        logic [31:0] read_value;
    } iorsp_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active requester at or after the priority pointer.
// Latency: grant is combinational from request; pointer moves on the clock after update_lru.
// Backpressure: pointer only advances when the grant is actually consumed (update_lru).
module rr_arbiter #(
    parameter int  NUM_REQUESTERS = 4,
    localparam int IDX_W          = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      grant_any
);

    logic [IDX_W-1:0] prio;

    // Pick the requester with the smallest circular distance from the priority pointer.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            for (int j = 0; j < NUM_REQUESTERS; j++) begin
                if (!grant_any && request[j] &&
                    (((j >= int'(prio)) ? (j - int'(prio))
                                        : (j + NUM_REQUESTERS - int'(prio))) == k)) begin
                    grant_any   = 1'b1;
                    grant_idx   = IDX_W'(j);
                    grant_oh[j] = 1'b1;
                end
            end
        end
    end

    // Move priority to the requester just after the one that was served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= '0;
        end else if (update_lru && grant_any) begin
            prio <= (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/io_interconnect.sv
// Serialises per-core IO requests onto a single external bus and broadcasts the response.
// Latency: grant N, bus strobe N+1, response one cycle after io_ack is sampled (min 3 cycles/txn).
// Backpressure: one transaction in flight; ii_ready stays low until the response cycle has passed.
module io_interconnect
    import io_interconnect_pkg::*;
#(
    parameter int NUM_CORES = `NUM_CORES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] ior_request_valid,
    input  ioreq_packet_t        ior_request [NUM_CORES],
    output logic [NUM_CORES-1:0] ii_ready,
    output logic                 ii_response_valid,
    output iorsp_packet_t        ii_response,
    output logic                 io_write_en,
    output logic                 io_read_en,
    output logic [31:0]          io_address,
    output logic [31:0]          io_write_data,
    input  logic [31:0]          io_read_data,
    input  logic                 io_ack
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESPOND
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [NUM_CORES-1:0] grant_oh;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 grant_accept;
    ioreq_packet_t        granted_pkt;
    logic [IDX_W-1:0]     lat_core;
    thread_idx_t          lat_thread;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_CORES)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .request    (ior_request_valid),
        .update_lru (grant_accept),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Select the granted core's packet with a one-hot mux.
    always_comb begin
        granted_pkt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_oh[i]) begin
                granted_pkt = ior_request[i];
            end
        end
    end

    // Next-state logic; ii_ready is only ever raised for the winner while idle.
    always_comb begin
        next_state   = state;
        ii_ready     = '0;
        grant_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any && !reset) begin
                    ii_ready     = grant_oh;
                    grant_accept = 1'b1;
                    next_state   = S_BUS;
                end
            end
            S_BUS: begin
                if (io_ack) begin
                    next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the granted request, drive the bus, and form the one-cycle response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_core          <= '0;
            lat_thread        <= '0;
            io_address        <= '0;
            io_write_data     <= '0;
            io_read_en        <= 1'b0;
            io_write_en       <= 1'b0;
            ii_response_valid <= 1'b0;
            ii_response       <= '0;
        end else begin
            ii_response_valid <= 1'b0;
            if (grant_accept) begin
                lat_core      <= grant_idx;
                lat_thread    <= granted_pkt.thread_idx;
                io_address    <= granted_pkt.address;
                io_write_data <= granted_pkt.value;
                io_read_en    <= !granted_pkt.store;
                io_write_en   <= granted_pkt.store;
            end
            if (state == S_BUS && io_ack) begin
                io_read_en              <= 1'b0;
                io_write_en             <= 1'b0;
                ii_response_valid       <= 1'b1;
                ii_response.core        <= core_id_t'(lat_core);
                ii_response.thread_idx  <= lat_thread;
                // io_write_en is still high here for a store, so it selects the zero value.
                ii_response.read_value  <= io_write_en ? 32'h0 : io_read_data;
            end
        end
    end

endmodule
